// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges pipeline writeback and buffered long-latency results onto one register-file write port
module wb_write_arbiter #(
  parameter int DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_pipe_we,
  input  logic [4:0]  wb_pipe_rd,
  input  logic [31:0] wb_pipe_data,
  input  logic        lq_valid,
  output logic        lq_ready,
  input  logic [4:0]  lq_rd,
  input  logic [31:0] lq_data,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wd,
  output logic [31:0] pend_mask,
  output logic        stall_req
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  localparam logic [CW-1:0] SMAX = STARVE_MAX[CW-1:0];
  logic [4:0]       rd_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] live_q;
  logic [AW-1:0]    head, tail;
  logic [AW:0]      count;
  logic [CW-1:0]    wcnt;
  logic             pipe_w, empty, pop, push, head_live;
  assign pipe_w    = wb_pipe_we && |wb_pipe_rd;
  assign empty     = count == '0;
  assign pop       = !pipe_w && !empty;
  assign head_live = live_q[head];
  assign lq_ready  = !rst && count < FULL;
  assign push      = lq_valid && lq_ready && |lq_rd;
  assign stall_req = !rst && wcnt == SMAX;
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (live_q[i]) pend_mask[rd_q[i]] = 1'b1;
    pend_mask[0] = 1'b0;
    if (rst) pend_mask = '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      wcnt   <= '0;
      live_q <= '0;
      rf_we  <= 1'b0;
      rf_rd  <= '0;
      rf_wd  <= '0;
    end else begin
      rf_we <= pipe_w || (pop && head_live);
      if (pipe_w) begin
        rf_rd <= wb_pipe_rd;
        rf_wd <= wb_pipe_data;
      end else if (pop && head_live) begin
        rf_rd <= rd_q[head];
        rf_wd <= data_q[head];
      end
      // a newer pipeline write makes any buffered result for the same rd stale
      for (int i = 0; i < DEPTH; i++)
        if (pipe_w && rd_q[i] == wb_pipe_rd) live_q[i] <= 1'b0;
      if (pop) begin
        live_q[head] <= 1'b0;
        head         <= head + 1'b1;
      end
      if (push) begin
        rd_q[tail]   <= lq_rd;
        data_q[tail] <= lq_data;
        live_q[tail] <= !(pipe_w && lq_rd == wb_pipe_rd);
        tail         <= tail + 1'b1;
      end
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      wcnt <= (empty || pop) ? '0 : (wcnt == SMAX ? wcnt : wcnt + 1'b1);
    end
  end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed stimulus against a queue-based reference model with an rf write scoreboard
module tb_wb_write_arbiter;
  localparam int DEPTH = 2;
  localparam int STARVE_MAX = 4;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_pipe_we = 1'b0;
  logic [4:0]  wb_pipe_rd = '0;
  logic [31:0] wb_pipe_data = '0;
  logic        lq_valid = 1'b0;
  logic        lq_ready;
  logic [4:0]  lq_rd = '0;
  logic [31:0] lq_data = '0;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic [31:0] pend_mask;
  logic        stall_req;
  wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .wb_pipe_we(wb_pipe_we), .wb_pipe_rd(wb_pipe_rd), .wb_pipe_data(wb_pipe_data),
    .lq_valid(lq_valid), .lq_ready(lq_ready), .lq_rd(lq_rd), .lq_data(lq_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .pend_mask(pend_mask), .stall_req(stall_req)
  );
  always #5 clk = ~clk;
  typedef struct {logic [4:0] rd; logic [31:0] data; logic live;} ent_t;
  typedef struct {logic we; logic [4:0] rd; logic [31:0] wd;} wr_t;
  ent_t mq[$];
  wr_t exp_q[$];
  int m_wcnt = 0;
  logic [4:0] m_rd = '0;
  logic [31:0] m_wd = '0;
  int passed = 0;
  int total = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask
  function automatic logic [31:0] model_mask(input logic r);
    logic [31:0] m = '0;
    foreach (mq[i]) if (mq[i].live) m[mq[i].rd] = 1'b1;
    return r ? 32'd0 : m;
  endfunction
  task automatic step(input logic r, input logic pwe, input logic [4:0] prd, input logic [31:0] pd,
                      input logic lv, input logic [4:0] lr, input logic [31:0] ld);
    logic pw, pop_m, rdy, was_empty;
    ent_t h;
    wr_t e;
    rst = r; wb_pipe_we = pwe; wb_pipe_rd = prd; wb_pipe_data = pd;
    lq_valid = lv; lq_rd = lr; lq_data = ld;
    if (r) begin
      mq.delete();
      m_wcnt = 0; m_rd = '0; m_wd = '0;
      e = '{1'b0, 5'd0, 32'd0};
    end else begin
      rdy = mq.size() < DEPTH;
      was_empty = mq.size() == 0;
      pw = pwe && prd != 0;
      pop_m = !pw && !was_empty;
      e = '{1'b0, m_rd, m_wd};
      if (pw) begin
        foreach (mq[i]) if (mq[i].rd == prd) mq[i].live = 1'b0;
        e = '{1'b1, prd, pd};
      end else if (pop_m) begin
        h = mq.pop_front();
        if (h.live) e = '{1'b1, h.rd, h.data};
      end
      if (lv && rdy && lr != 0) mq.push_back('{lr, ld, !(pw && lr == prd)});
      m_wcnt = (was_empty || pop_m) ? 0 : (m_wcnt == STARVE_MAX ? m_wcnt : m_wcnt + 1);
      m_rd = e.rd; m_wd = e.wd;
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    chk("pend_mask", pend_mask, model_mask(r));
    chk("lq_ready", {31'd0, lq_ready}, (!r && mq.size() < DEPTH) ? 32'd1 : 32'd0);
    chk("stall_req", {31'd0, stall_req}, (!r && m_wcnt == STARVE_MAX) ? 32'd1 : 32'd0);
  endtask
  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rf_we", {31'd0, rf_we}, {31'd0, e.we});
        chk("rf_rd", {27'd0, rf_rd}, {27'd0, e.rd});
        chk("rf_wd", rf_wd, e.wd);
      end
    end
  end
  initial begin
    logic [4:0] r5;
    repeat (2) step(1'b1, 1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2);
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_mask", pend_mask, 32'd0);
    chk("rst_ready", {31'd0, lq_ready}, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    idle();
    chk("ready_after_rst", {31'd0, lq_ready}, 32'd1);
    step(1'b0, 1'b1, 5'd5, 32'h11111111, 1'b1, 5'd6, 32'h22222222);
    chk("prio_we", {31'd0, rf_we}, 32'd1);
    chk("prio_rd", {27'd0, rf_rd}, 32'd5);
    chk("prio_wd", rf_wd, 32'h11111111);
    chk("prio_mask", pend_mask, 32'h40);
    idle();
    chk("prio_lq_rd", {27'd0, rf_rd}, 32'd6);
    chk("prio_lq_wd", rf_wd, 32'h22222222);
    step(1'b0, 1'b1, 5'd1, 32'h100, 1'b1, 5'd7, 32'h777);
    step(1'b0, 1'b1, 5'd1, 32'h101, 1'b1, 5'd8, 32'h888);
    chk("full_ready", {31'd0, lq_ready}, 32'd0);
    chk("full_mask", pend_mask, 32'h180);
    step(1'b0, 1'b1, 5'd1, 32'h102, 1'b1, 5'd9, 32'h999);
    step(1'b0, 1'b1, 5'd1, 32'h103, 1'b0, 5'd0, 32'd0);
    chk("stall_pre", {31'd0, stall_req}, 32'd0);
    step(1'b0, 1'b1, 5'd1, 32'h104, 1'b0, 5'd0, 32'd0);
    chk("stall_set", {31'd0, stall_req}, 32'd1);
    step(1'b0, 1'b1, 5'd1, 32'h105, 1'b0, 5'd0, 32'd0);
    chk("stall_sat", {31'd0, stall_req}, 32'd1);
    idle();
    chk("drain1_rd", {27'd0, rf_rd}, 32'd7);
    chk("drain1_stall", {31'd0, stall_req}, 32'd0);
    idle();
    chk("drain2_rd", {27'd0, rf_rd}, 32'd8);
    chk("drain2_wd", rf_wd, 32'h888);
    idle();
    step(1'b0, 1'b1, 5'd1, 32'h200, 1'b1, 5'd9, 32'hAAAA0000);
    chk("waw_mask_set", pend_mask, 32'h200);
    step(1'b0, 1'b1, 5'd9, 32'h0000BBBB, 1'b0, 5'd0, 32'd0);
    chk("waw_mask_clr", pend_mask, 32'd0);
    chk("waw_wd", rf_wd, 32'h0000BBBB);
    idle();
    chk("waw_pop_we", {31'd0, rf_we}, 32'd0);
    chk("waw_hold_wd", rf_wd, 32'h0000BBBB);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
    chk("x0_push_mask", pend_mask, 32'd0);
    idle();
    chk("x0_push_we", {31'd0, rf_we}, 32'd0);
    step(1'b0, 1'b1, 5'd1, 32'h300, 1'b1, 5'd3, 32'h333);
    step(1'b0, 1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0);
    chk("x0_pipe_we", {31'd0, rf_we}, 32'd1);
    chk("x0_pipe_rd", {27'd0, rf_rd}, 32'd3);
    chk("x0_pipe_wd", rf_wd, 32'h333);
    step(1'b0, 1'b1, 5'd12, 32'hC0, 1'b1, 5'd12, 32'hC1);
    chk("same_kill_mask", pend_mask, 32'd0);
    idle();
    chk("same_kill_we", {31'd0, rf_we}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      r5 = 5'(10 + i);
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, r5, 32'(r5) * 3);
      chk("wrap_ready", {31'd0, lq_ready}, 32'd1);
    end
    idle();
    chk("wrap_last_rd", {27'd0, rf_rd}, 32'd19);
    chk("wrap_last_wd", rf_wd, 32'd57);
    step(1'b0, 1'b1, 5'd1, 32'h400, 1'b1, 5'd20, 32'h14);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    idle();
    chk("midrst_mask", pend_mask, 32'd0);
    idle();
    chk("midrst_we", {31'd0, rf_we}, 32'd0);
    @(negedge clk); #1;
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
